// File: rtl/ebus_sram_arbiter_pkg.sv
// Shared types for the ebus SRAM arbiter: FSM states, pin bundle
// and round-robin index helpers.
package ebus_sram_arbiter_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_HOLD,
      ST_RELEASED
   } state_t;

   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic d_oe;
   } pin_ctl_t;

   localparam pin_ctl_t CTL_IDLE = '{
      ce_n: 1'b1,
      oe_n: 1'b1,
      we_n: 1'b1,
      d_oe: 1'b0
   };

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int wrap_idx(input int p, input int i, input int n);
      int s;
      s = p + i;
      return (s >= n) ? s - n : s;
   endfunction

endpackage

// File: rtl/ebus_sram_arbiter_if.sv
// Channel-side bus of the SRAM arbiter: packed per-channel requests
// in, one-hot completion and shared read data out.
interface ebus_sram_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 19
);
   import ebus_sram_arbiter_pkg::*;

   logic [NUM_CH-1:0]        ch_req;
   logic [NUM_CH-1:0]        ch_we;
   logic [NUM_CH*ADDR_W-1:0] ch_addr;
   logic [NUM_CH*DATA_W-1:0] ch_wrdata;
   logic [NUM_CH-1:0]        ch_ack;
   logic [DATA_W-1:0]        rddata;

   modport master (
      output ch_req, ch_we, ch_addr, ch_wrdata,
      input  ch_ack, rddata
   );

   modport slave (
      input  ch_req, ch_we, ch_addr, ch_wrdata,
      output ch_ack, rddata
   );

endinterface

// File: rtl/ebus_sram_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping,
// returned as one-hot grant plus its index.
module rr_arbiter
   import ebus_sram_arbiter_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int PW     = ptr_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [PW-1:0]     ptr,
   output logic [NUM_CH-1:0] gnt,
   output logic [PW-1:0]     gnt_idx,
   output logic              vld
);

   logic [PW-1:0] c;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      vld     = 1'b0;
      c       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         c = PW'(wrap_idx(int'(ptr), i, NUM_CH));
         if (!vld && req[c]) begin
            vld     = 1'b1;
            gnt_idx = c;
            gnt[c]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ebus_sram_arbiter.sv
// Round-robin arbiter and cycle generator for the external ebus SRAM.
// SRAM_ARB_BUSREQ_EN adds bus release to an external busreq_n master.
module ebus_sram_arbiter
   import ebus_sram_arbiter_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int ADDR_W      = 19,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   ebus_sram_arbiter_if.slave bus,
   output logic [ADDR_W-1:0]  sram_a,
   output logic               sram_a_oe,
   output logic [DATA_W-1:0]  sram_d_out,
   output logic               sram_d_oe,
   input  logic [DATA_W-1:0]  sram_d_in,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   input  logic               ebus_busreq_n,
   output logic               ebus_busack_n
);

   localparam int PW = ptr_w(NUM_CH);

   state_t            state, state_nx;
   logic [PW-1:0]     ptr, gnt_idx;
   logic [NUM_CH-1:0] gnt;
   logic              gnt_vld, busreq, take, last_acc;
   logic [2:0]        wait_cnt;

   logic [ADDR_W-1:0] t_addr, t_addr_nx, a_nx;
   logic [DATA_W-1:0] t_data, t_data_nx, dout_nx, rd_q;
   logic              t_we, t_we_nx;
   logic [NUM_CH-1:0] t_gnt, t_gnt_nx, ack_q, ack_nx;
   pin_ctl_t          ctl_q, ctl_nx;

   rr_arbiter #(.NUM_CH(NUM_CH), .PW(PW)) u_rr (
      .req     (bus.ch_req),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .vld     (gnt_vld)
   );

`ifdef SRAM_ARB_BUSREQ_EN
   logic a_oe_q, busack_q;

   assign busreq = ~ebus_busreq_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_oe_q   <= 1'b1;
         busack_q <= 1'b1;
      end else begin
         a_oe_q   <= (state_nx != ST_RELEASED);
         busack_q <= (state_nx != ST_RELEASED);
      end
   end

   assign sram_a_oe     = a_oe_q;
   assign ebus_busack_n = busack_q;
`else
   logic unused_busreq_n;

   assign unused_busreq_n = ebus_busreq_n;
   assign busreq          = 1'b0;
   assign sram_a_oe       = 1'b1;
   assign ebus_busack_n   = 1'b1;
`endif

   // External bus request wins over channels, but only from IDLE
   assign take     = (state == ST_IDLE) && !busreq && gnt_vld;
   assign last_acc = (state == ST_ACCESS) &&
                     (wait_cnt == 3'(WAIT_CYCLES));

   assign t_we_nx   = take ? bus.ch_we[gnt_idx] : t_we;
   assign t_addr_nx = take ?
      bus.ch_addr[int'(gnt_idx)*ADDR_W +: ADDR_W] : t_addr;
   assign t_data_nx = take ?
      bus.ch_wrdata[int'(gnt_idx)*DATA_W +: DATA_W] : t_data;
   assign t_gnt_nx  = take ? gnt : t_gnt;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (busreq)       state_nx = ST_RELEASED;
            else if (gnt_vld) state_nx = ST_SETUP;
         end
         ST_SETUP:    state_nx = ST_ACCESS;
         ST_ACCESS:   if (last_acc) state_nx = ST_HOLD;
         ST_HOLD:     state_nx = ST_IDLE;
         ST_RELEASED: if (!busreq) state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
   end

   // Pin values for the coming state, so every pin leaves a flop
   always_comb begin
      ctl_nx  = CTL_IDLE;
      a_nx    = sram_a;
      dout_nx = sram_d_out;
      ack_nx  = '0;
      unique case (state_nx)
         ST_SETUP: begin
            ctl_nx.ce_n = 1'b0;
            ctl_nx.oe_n = t_we_nx;
            ctl_nx.d_oe = t_we_nx;
            a_nx        = t_addr_nx;
            dout_nx     = t_data_nx;
         end
         ST_ACCESS: begin
            ctl_nx.ce_n = 1'b0;
            ctl_nx.oe_n = t_we_nx;
            ctl_nx.d_oe = t_we_nx;
            ctl_nx.we_n = ~t_we_nx;
         end
         ST_HOLD: begin
            ctl_nx.d_oe = t_we_nx;
            ack_nx      = t_gnt_nx;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr        <= '0;
         wait_cnt   <= '0;
         t_addr     <= '0;
         t_data     <= '0;
         t_we       <= 1'b0;
         t_gnt      <= '0;
         ctl_q      <= CTL_IDLE;
         sram_a     <= '0;
         sram_d_out <= '0;
         ack_q      <= '0;
         rd_q       <= '0;
      end else begin
         t_addr     <= t_addr_nx;
         t_data     <= t_data_nx;
         t_we       <= t_we_nx;
         t_gnt      <= t_gnt_nx;
         ctl_q      <= ctl_nx;
         sram_a     <= a_nx;
         sram_d_out <= dout_nx;
         ack_q      <= ack_nx;
         if (take)
            ptr <= (gnt_idx == PW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
         if (state == ST_ACCESS) wait_cnt <= wait_cnt + 3'd1;
         else                    wait_cnt <= '0;
         if (last_acc && !t_we) rd_q <= sram_d_in;
      end
   end

   assign sram_ce_n  = ctl_q.ce_n;
   assign sram_oe_n  = ctl_q.oe_n;
   assign sram_we_n  = ctl_q.we_n;
   assign sram_d_oe  = ctl_q.d_oe;
   assign bus.ch_ack = ack_q;
   assign bus.rddata = rd_q;

endmodule
